tdm_demux: RTL

Receive end of the team's time-division multiplexed link: takes one shared word stream, built by chaining mux2to1 stages under a slot select, and distributes each word to its per-channel output register.
- Tracks slot position with a frame-sync marker, a slot counter and a HUNT/LOCKED state machine.
- Holds the last word per channel, with per-channel valid pulses.
- Sits between the serial link receiver and the per-channel consumers.

---
 rtl/tdm_demux_pkg.sv | 16 +
 rtl/tdm_slot_ctr.sv | 34 +++
 rtl/tdm_demux.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types, default sizes and helpers for the TDM link receiver (tdm_demux).
package tdm_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

  function automatic int slot_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter for tdm_demux: reloads to 1 on a frame start, otherwise
// counts accepted words and wraps to 0 after max.
module tdm_slot_ctr #(
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr_to_one,
  input  logic [SW-1:0] max,
  output logic [SW-1:0] slot
);

  logic [SW-1:0] slot_q, slot_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    slot_d = slot_q;
    if (clr_to_one) begin
      slot_d = SW'(1);
    end else if (inc) begin
      slot_d = (slot_q == max) ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM link receiver: HUNT/LOCKED frame tracking and per-channel word demux.
// Optional macro TDM_DEMUX_FRAME_LATCH_EN: publish whole frames from a shadow bank.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              sync_i,
  input  logic [W-1:0]      data_i,
  output logic [N_CH*W-1:0] ch_data_o,
  output logic [N_CH-1:0]   ch_valid_o,
  output logic              frame_done_o,
  output logic              locked_o,
  output logic              sync_err_o
);

  localparam int            SW   = slot_width(N_CH);
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] slot, wr_ch;
  logic          accept, inc, clr_to_one, err_set, done_d;
  logic [N_CH-1:0] sel;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    wr_ch      = '0;
    inc        = 1'b0;
    clr_to_one = 1'b0;
    err_set    = 1'b0;
    done_d     = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (sync_i) begin
            accept     = 1'b1;
            clr_to_one = 1'b1;
            state_d    = LOCKED;
          end
        end
        LOCKED: begin
          if (sync_i) begin
            // A sync anywhere but slot 0 abandons the partial frame and resyncs here.
            accept     = 1'b1;
            clr_to_one = 1'b1;
            err_set    = (slot != '0);
          end else if (slot != '0) begin
            accept = 1'b1;
            wr_ch  = slot;
            inc    = 1'b1;
            done_d = (slot == LAST);
          end else begin
            err_set = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  tdm_slot_ctr #(.SW(SW)) u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (inc),
    .clr_to_one (clr_to_one),
    .max        (LAST),
    .slot       (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  assign sel = accept ? (N_CH'(1) << wr_ch) : '0;

  logic [W-1:0]    ch_q [N_CH];
  logic [N_CH-1:0] ch_valid_q;
  logic            frame_done_q, sync_err_q;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [W-1:0] shadow_q [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the channel banks are a handful of flops whose value is visible at reset, so they are reset too.
      for (int k = 0; k < N_CH; k++) begin
        shadow_q[k] <= '0;
        ch_q[k]     <= '0;
      end
      ch_valid_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (sel[k]) shadow_q[k] <= data_i;
        // The last word bypasses the shadow so the whole frame lands in one edge.
        if (done_d) ch_q[k] <= sel[k] ? data_i : shadow_q[k];
      end
      ch_valid_q <= done_d ? '1 : '0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) ch_q[k] <= '0;
      ch_valid_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (sel[k]) ch_q[k] <= data_i;
      end
      ch_valid_q <= sel;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      frame_done_q <= done_d;
      sync_err_q   <= sync_err_q | err_set;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign ch_data_o[k*W +: W] = ch_q[k];
  end

  assign ch_valid_o   = ch_valid_q;
  assign frame_done_o = frame_done_q;
  assign locked_o     = (state_q == LOCKED);
  assign sync_err_o   = sync_err_q;

endmodule
